// File: rtl/pe_pkg.sv
// pe_pkg: shared PE types and default psum scratchpad geometry.
package pe_pkg;

    localparam int PSUM_WIDTH_DEF = 16;
    localparam int PSUM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/psum_skid_buf.sv
// psum_skid_buf: 2-entry FIFO of {last, addr, data} between scratchpad read and output stream.
module psum_skid_buf #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   occ,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wp_q, wp_d, rp_q, rp_d;
    logic [1:0]   occ_q, occ_d;

    // A push into a full buffer only happens alongside a pop, so it reuses the slot being vacated.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign occ   = occ_q;
    assign full  = occ_q == 2'd2;
    assign empty = occ_q == 2'd0;

endmodule

// File: rtl/psum_drain.sv
// psum_drain: reads psums 0..N-1 from the scratchpad and streams them out with a last marker.
// Optional PSUM_DRAIN_CLEAR_EN adds clr_en/clr_addr to zero each entry as it is accepted.
module psum_drain
    import pe_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int PSUM_DEPTH = PSUM_DEPTH_DEF,
    parameter int ADDR_W     = $clog2(PSUM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [PSUM_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_data,
`ifdef PSUM_DRAIN_CLEAR_EN
    output logic                  clr_en,
    output logic [ADDR_W-1:0]     clr_addr,
`endif
    output logic                  out_last
);

    localparam int EW = 1 + ADDR_W + PSUM_WIDTH;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(PSUM_DEPTH);

    drain_state_e      state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d, ptr_q, ptr_d;
    logic              infl_q, infl_last_q, infl_last_d;
    logic [ADDR_W-1:0] infl_addr_q, out_addr;
    logic [EW-1:0]     head;
    logic [1:0]        occ;
    logic [2:0]        load;
    logic              hs, empty, unused_full;

    assign hs        = out_valid & out_ready;
    assign out_valid = ~empty;
    assign load      = 3'(occ) + 3'(infl_q) - 3'(hs);
    assign rd_en     = (state_q == DRAIN) && (ptr_q < n_q) && (load < 3'd2);
    assign rd_addr   = ptr_q[ADDR_W-1:0];
    assign busy      = state_q == DRAIN;
    assign done      = state_q == DONE;
    assign infl_last_d = ptr_q == n_q - (ADDR_W + 1)'(1);
    assign {out_last, out_addr, out_data} = head;

    // A zero-length drain passes through DRAIN for one cycle so done keeps its usual spacing.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE && start) begin
            n_d     = count > DEPTH_C ? DEPTH_C : count;
            ptr_d   = '0;
            state_d = DRAIN;
        end else if (state_q == DRAIN) begin
            ptr_d   = ptr_q + (ADDR_W + 1)'(rd_en);
            state_d = ((hs && out_last) || n_q == '0) ? DONE : DRAIN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            ptr_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            ptr_q       <= ptr_d;
            infl_q      <= rd_en;
            infl_last_q <= infl_last_d;
            infl_addr_q <= ptr_q[ADDR_W-1:0];
        end
    end

    psum_skid_buf #(.W(EW)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (infl_q),
        .pop  (hs),
        .din  ({infl_last_q, infl_addr_q, rd_data}),
        .dout (head),
        .occ  (occ),
        .full (unused_full),
        .empty(empty)
    );

`ifdef PSUM_DRAIN_CLEAR_EN
    assign clr_en   = hs;
    assign clr_addr = out_addr;
`else
    logic unused_addr;
    assign unused_addr = ^out_addr;
`endif

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed and randomized drains checked against an expected-sequence model.
module tb_psum_drain;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [4:0]  count = '0;
    logic        busy, done, rd_en, out_valid, out_last;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data = '0, out_data;
    logic [15:0] spad [16];
    logic [7:0]  pat = 8'b0110_1001;
    int          checks = 0, errors = 0;
    int          fv, dc;
`ifdef PSUM_DRAIN_CLEAR_EN
    logic        clr_en;
    logic [3:0]  clr_addr;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= spad[rd_addr];

    psum_drain dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
`ifdef PSUM_DRAIN_CLEAR_EN
        .clr_en(clr_en), .clr_addr(clr_addr),
`endif
        .out_last(out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: fixed 1,0,0,1,0,1,1,0 pattern, 2: random ready
    task automatic drain(input int cnt, input int mode, output int first_v, output int done_c);
        int n = cnt > 16 ? 16 : cnt;
        int issued = 0, acc = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [15:0] pd = '0;
        logic [3:0] ai;
        first_v = -1;
        done_c  = -1;
        @(posedge clk); #1 start = 1'b1; count = 5'(cnt); out_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        for (int c = 1; c < 300 && done_c < 0; c++) begin
            @(posedge clk); #1
            start = 1'b0;
            count = 5'($urandom);
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[(c - 1) % 8] : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("outstanding_le2", 32'(issued - acc <= 2), 1);
            if (rd_en) begin
                chk("rd_addr", rd_addr, issued);
                chk("rd_excess", 32'(issued < n), 1);
                issued++;
            end
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_last", out_last, pl);
            end
            if (out_valid && first_v < 0) first_v = c;
            if (n == 0) chk("zero_no_valid", out_valid, 0);
`ifdef PSUM_DRAIN_CLEAR_EN
            chk("clr_en", clr_en, 32'(out_valid && out_ready));
            if (out_valid && out_ready) chk("clr_addr", clr_addr, 32'(acc));
`endif
            if (out_valid && out_ready) begin
                chk("extra_word", 32'(acc < n), 1);
                ai = 4'(acc);
                if (acc < n) begin
                    chk("data", out_data, spad[ai]);
                    chk("last", out_last, 32'(acc == n - 1));
                end
                acc++;
            end
            if (done) begin
                done_c = c;
                chk("word_count", acc, n);
                chk("busy_at_done", busy, 0);
            end else if (n > 0) begin
                chk("busy", busy, 1);
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
        chk("done_timeout", 32'(done_c >= 0), 1);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int acc;
        bit hit;
        for (int i = 0; i < 16; i++) spad[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        @(posedge clk); #1 rst = 1'b0;

        spad[0] = 16'd10; spad[1] = 16'd20; spad[2] = 16'd30; spad[3] = 16'd40;
        drain(4, 0, fv, dc);
        chk("n4_first_valid", fv, 3);
        chk("n4_done_cycle", dc, 7);

        drain(0, 0, fv, dc);
        chk("n0_done_cycle", dc, 2);
        chk("n0_no_valid", fv, 32'(-1));

        for (int i = 0; i < 16; i++) spad[i] = 16'($urandom);
        drain(8, 1, fv, dc);
        drain(20, 0, fv, dc);
        chk("n20_done_cycle", dc, 19);
        drain(4, 1, fv, dc);

        // reset while word 3 of an 8-word drain is stalled
        acc = 0;
        hit = 1'b0;
        @(posedge clk); #1 start = 1'b1; count = 5'd8;
        for (int c = 1; c < 100 && !hit; c++) begin
            @(posedge clk); #1 start = 1'b0; out_ready = acc < 2;
            @(negedge clk);
            if (out_valid && out_ready) acc++;
            else if (out_valid && acc == 2) hit = 1'b1;
        end
        chk("rst_word3_reached", 32'(hit), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        for (int i = 0; i < 16; i++) spad[i] = 16'($urandom);
        drain(2, 0, fv, dc);
        chk("post_rst_done_cycle", dc, 5);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) spad[i] = 16'($urandom);
            drain(int'($urandom_range(0, 31)), 2, fv, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
